gpio_debounce: RTL and testbench

- Input-conditioning front end, directly upstream of the GPIO controller's pin inputs.
- Synchronises raw external pin levels and filters each pin with an independent debounce counter, timed by a shared prescaler tick.
- Emits clean levels plus one-cycle rise/fall pulses.
- The clean levels feed the controller's input path, so mechanical bounce never reaches its edge-interrupt logic.

---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_debounce_if.sv | 35 +++
 rtl/gpio_debounce_pin.sv | 87 ++++++++
 rtl/gpio_debounce.sv | 78 +++++++
 tb/tb_gpio_debounce.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and FSM encoding for the GPIO debounce front end.
// Imported by the interface, the per-pin filter and the top level.
package gpio_pkg;

  localparam int GPIO_NUM_PINS  = 16;
  localparam int GPIO_CNT_WIDTH = 8;
  localparam int PS_W           = 16;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/gpio_debounce_if.sv
// Pin-side bundle of the debounce front end: raw pins and threshold in,
// clean levels, edge pulses and glitch count out.
interface gpio_debounce_if
  import gpio_pkg::*;
#(
  parameter int NUM_PINS  = GPIO_NUM_PINS,
  parameter int CNT_WIDTH = GPIO_CNT_WIDTH
);

  logic [NUM_PINS-1:0]  pins_raw;
  logic [CNT_WIDTH-1:0] threshold;
  logic [NUM_PINS-1:0]  pins_clean;
  logic [NUM_PINS-1:0]  rise_pulse;
  logic [NUM_PINS-1:0]  fall_pulse;
  logic [15:0]          glitch_count;

  modport master (
    output pins_raw,
    output threshold,
    input  pins_clean,
    input  rise_pulse,
    input  fall_pulse,
    input  glitch_count
  );

  modport slave (
    input  pins_raw,
    input  threshold,
    output pins_clean,
    output rise_pulse,
    output fall_pulse,
    output glitch_count
  );

endinterface

// File: rtl/gpio_debounce_pin.sv
// One pin: 2-flop synchroniser, tick-timed stability counter and FSM,
// registered rise/fall pulses and a one-cycle glitch flag.
module gpio_debounce_pin
  import gpio_pkg::*;
#(
  parameter int   CW      = GPIO_CNT_WIDTH,
  parameter logic RST_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          raw_i,
  input  logic          tick_i,
  input  logic [CW-1:0] thr_i,
  output logic          clean_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic          glitch_o
);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic          rise_q;
  logic          fall_q;
  logic          glitch_q;
  state_e        st_q;
  logic [CW-1:0] cnt_q;

  logic          diff;
  logic [CW-1:0] eff_cnt;
  logic [CW-1:0] thr_m1;

  assign diff    = sync2_q ^ clean_q;
  assign eff_cnt = (st_q == ST_PENDING) ? cnt_q : '0;
  assign thr_m1  = thr_i - 1'b1;

  // The edge that first sees a mismatch already counts as a tick,
  // giving latency 1+T edges when every cycle is a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      clean_q  <= RST_VAL;
      st_q     <= ST_STABLE;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      if (thr_i == '0) begin
        clean_q <= sync2_q;
        st_q    <= ST_STABLE;
        cnt_q   <= '0;
        rise_q  <= diff & sync2_q;
        fall_q  <= diff & ~sync2_q;
      end else if (!diff) begin
        cnt_q    <= '0;
        st_q     <= ST_STABLE;
        glitch_q <= (st_q == ST_PENDING);
      end else if (tick_i) begin
        if (eff_cnt >= thr_m1) begin
          clean_q <= sync2_q;
          cnt_q   <= '0;
          st_q    <= ST_STABLE;
          rise_q  <= sync2_q;
          fall_q  <= ~sync2_q;
        end else begin
          cnt_q <= (&eff_cnt) ? eff_cnt : eff_cnt + 1'b1;
          st_q  <= ST_PENDING;
        end
      end else begin
        st_q <= ST_PENDING;
      end
    end
  end

  assign clean_o  = clean_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = glitch_q;

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input debounce: shared prescaler tick feeding NUM_PINS filters.
// Define GPIO_DEBOUNCE_GLITCH_CNT_EN to build the saturating glitch counter.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int                  NUM_PINS  = GPIO_NUM_PINS,
  parameter int                  CNT_WIDTH = GPIO_CNT_WIDTH,
  parameter int                  PRESCALE  = 1000,
  parameter logic [NUM_PINS-1:0] RESET_VAL = {NUM_PINS{1'b0}}
) (
  input logic            clk,
  input logic            rst_n,
  gpio_debounce_if.slave bus
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     pre_q;
  logic [PS_W-1:0]     pre_d;
  logic                tick;
  logic [NUM_PINS-1:0] clean;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] glitch;

  assign tick  = (pre_q == PS_LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_debounce_pin #(
      .CW      (CNT_WIDTH),
      .RST_VAL (RESET_VAL[i])
    ) u_pin (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (bus.pins_raw[i]),
      .tick_i   (tick),
      .thr_i    (bus.threshold),
      .clean_o  (clean[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .glitch_o (glitch[i])
    );
  end

  assign bus.pins_clean = clean;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] gcnt_q;
  logic [15:0] gcnt_d;

  assign gcnt_d = (|glitch && gcnt_q != 16'hFFFF) ? gcnt_q + 16'd1 : gcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign bus.glitch_count = gcnt_q;
`else
  // Flags are masked away; the constant zero leaves no counter logic.
  assign bus.glitch_count = 16'h0 & {16{|glitch}};
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge
// monitor pops and compares whenever a DUT shows a rise/fall pulse.
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  typedef struct {
    int          lo;
    int          hi;
    logic [15:0] r;
    logic [15:0] f;
    logic [15:0] c;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   s;
  ev_t  qa[$];
  ev_t  qb[$];

  gpio_debounce_if #(.NUM_PINS(16), .CNT_WIDTH(8)) ifa ();
  gpio_debounce_if #(.NUM_PINS(16), .CNT_WIDTH(8)) ifb ();

  gpio_debounce #(
    .NUM_PINS(16), .CNT_WIDTH(8), .PRESCALE(1), .RESET_VAL(16'h0000)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  gpio_debounce #(
    .NUM_PINS(16), .CNT_WIDTH(8), .PRESCALE(10), .RESET_VAL(16'h00F0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int lo, input int hi,
                      input logic [15:0] r, input logic [15:0] f,
                      input logic [15:0] c);
    ev_t e;
    e.lo = lo; e.hi = hi; e.r = r; e.f = f; e.c = c;
    if (id == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic mon(input int id, input logic [15:0] r,
                     input logic [15:0] f, input logic [15:0] c);
    ev_t e;
    int  n;
    forever begin
      n = (id == 0) ? qa.size() : qb.size();
      if (n == 0) break;
      if (id == 0) e = qa[0];
      else e = qb[0];
      if (e.hi >= cyc) break;
      ncmp++;
      nfail++;
      $display("FAIL missing_pulse dut%0d: none by cycle %0d, required r=%h f=%h in %0d..%0d",
               id, cyc, e.r, e.f, e.lo, e.hi);
      if (id == 0) void'(qa.pop_front());
      else void'(qb.pop_front());
    end
    if ((r | f) == 16'h0) return;
    ncmp++;
    n = (id == 0) ? qa.size() : qb.size();
    if (n == 0) begin
      nfail++;
      $display("FAIL unexpected_pulse dut%0d cycle %0d: got r=%h f=%h, required none",
               id, cyc, r, f);
      return;
    end
    if (id == 0) e = qa.pop_front();
    else e = qb.pop_front();
    if (cyc < e.lo || cyc > e.hi || r !== e.r || f !== e.f || c !== e.c) begin
      nfail++;
      $display("FAIL pulse dut%0d: got cyc=%0d r=%h f=%h clean=%h, required cyc %0d..%0d r=%h f=%h clean=%h",
               id, cyc, r, f, c, e.lo, e.hi, e.r, e.f, e.c);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.rise_pulse, ifa.fall_pulse, ifa.pins_clean);
    mon(1, ifb.rise_pulse, ifb.fall_pulse, ifb.pins_clean);
  end

  initial begin
    rst_n = 1'b0;
    ifa.pins_raw  = 16'h0000;
    ifa.threshold = 8'd0;
    ifb.pins_raw  = 16'h00F0;
    ifb.threshold = 8'd3;
    step(3);
    chk("rst_clean_a", ifa.pins_clean, 16'h0000);
    chk("rst_clean_b", ifb.pins_clean, 16'h00F0);
    chk("rst_pulses_a", ifa.rise_pulse | ifa.fall_pulse, 16'h0000);
    chk("rst_glitch_a", ifa.glitch_count, 16'h0000);
    rst_n = 1'b1;
    step(3);

    s = cyc + 1;
    ifb.pins_raw[0] = 1'b1;
    push(1, s + 22, s + 32, 16'h0001, 16'h0000, 16'h00F1);
    step(40);
    chk("pre_clean_b", ifb.pins_clean, 16'h00F1);
    ifb.pins_raw[1] = 1'b1;
    step(15);
    ifb.pins_raw[1] = 1'b0;
    step(20);
    chk("pre_glitch_clean_b", ifb.pins_clean, 16'h00F1);
    chk("pre_glitch_cnt_b", ifb.glitch_count, GEN ? 16'd1 : 16'd0);

    s = cyc + 1;
    ifa.pins_raw[3] = 1'b1;
    push(0, s + 2, s + 2, 16'h0008, 16'h0000, 16'h0008);
    step(6);
    s = cyc + 1;
    ifa.pins_raw[3] = 1'b0;
    push(0, s + 2, s + 2, 16'h0000, 16'h0008, 16'h0000);
    step(6);

    ifa.threshold = 8'd4;
    step(1);
    s = cyc + 1;
    ifa.pins_raw[0] = 1'b1;
    push(0, s + 5, s + 5, 16'h0001, 16'h0000, 16'h0001);
    step(10);
    s = cyc + 1;
    ifa.pins_raw[0] = 1'b0;
    push(0, s + 5, s + 5, 16'h0000, 16'h0001, 16'h0000);
    step(10);

    ifa.pins_raw[1] = 1'b1;
    step(2);
    ifa.pins_raw[1] = 1'b0;
    step(10);
    chk("glitch_clean_a", ifa.pins_clean, 16'h0000);
    chk("glitch_cnt_a", ifa.glitch_count, GEN ? 16'd1 : 16'd0);

    ifa.threshold = 8'd200;
    step(1);
    s = cyc + 1;
    ifa.pins_raw[2] = 1'b1;
    step(52);
    ifa.threshold = 8'd10;
    push(0, s + 52, s + 52, 16'h0004, 16'h0000, 16'h0004);
    step(5);
    s = cyc + 1;
    ifa.pins_raw[2] = 1'b0;
    push(0, s + 11, s + 11, 16'h0000, 16'h0004, 16'h0000);
    step(16);

    ifa.threshold = 8'd4;
    step(1);
    s = cyc + 1;
    ifa.pins_raw = 16'h8001;
    push(0, s + 5, s + 5, 16'h8001, 16'h0000, 16'h8001);
    step(10);

    ifa.pins_raw[7] = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clean_a", ifa.pins_clean, 16'h0000);
    chk("mid_rst_pulses_a", ifa.rise_pulse | ifa.fall_pulse, 16'h0000);
    chk("mid_rst_clean_b", ifb.pins_clean, 16'h00F0);
    ifa.pins_raw = 16'h0000;
    ifb.pins_raw = 16'h00F0;
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("post_rst_clean_a", ifa.pins_clean, 16'h0000);

    for (int i = 0; i < 65600; i++) begin
      ifa.pins_raw = (i % 2 == 0) ? 16'h0010 : 16'h0020;
      step(1);
    end
    ifa.pins_raw = 16'h0000;
    step(10);
    chk("sat_clean_a", ifa.pins_clean, 16'h0000);
    chk("sat_glitch_a", ifa.glitch_count, GEN ? 16'hFFFF : 16'h0000);

    step(5);
    ncmp++;
    if (qa.size() + qb.size() != 0) begin
      nfail++;
      $display("FAIL leftover_events: got %0d pending, required 0",
               qa.size() + qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
